uart_rx_ovs: RTL and testbench
==============================

// Module: uart_rx_ovs
// PURPOSE
//  Parametrised UART receiver; successor to the fixed 8-bit receiver.
//  Configurable data width, parity mode and stop-bit count; mid-bit sampling.
//  Received frames go into an output FIFO with per-frame error tags, drained by ready/valid.
//  Sits between the board RX pin and the game-logic consumer.
// PARAMETERS
//  CLKS_PER_BAUD  1250  clk cycles per bit; >=8, legal for any value
//  DATA_BITS      8     data bits per frame, 5..9, LSB first on the wire
//  PARITY_MODE    2     0=none, 1=odd, 2=even (uart_pkg::PAR_*)
//  STOP_BITS      1     1 or 2
//  FIFO_DEPTH     4     output FIFO entries, power of 2, >=2
// PORTS
//  clk            in   1          system clock
//  rst            in   1          async active-high reset
//  rx_serial      in   1          raw asynchronous serial line, idle high
//  rx_data        out  DATA_BITS  FIFO head data
//  rx_parity_err  out  1          head frame had a parity mismatch (0 if PARITY_MODE=0)
//  rx_frame_err   out  1          head frame had a stop bit sampled low
//  rx_valid       out  1          FIFO non-empty
//  rx_ready       in   1          consumer accepts head when rx_valid&rx_ready
//  overrun        out  1          sticky: a frame was dropped because the FIFO was full
//  ovr_clr        in   1          clears overrun (set wins if same cycle)
//  busy           out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset: clk and rst as named above; rst async, active-high. On rst: FSM=IDLE, sync flops=1,
//   FIFO empty, rx_valid=0, rx_data=0, both err=0, overrun=0, busy=0. Mid-frame rst aborts the frame.
//  rx_serial passes through a 2-flop synchroniser (reset 1); FSM sees only the synchronised line.
//  Baud counter: cnt counts 0..CLKS_PER_BAUD-1; sample point MID=CLKS_PER_BAUD/2 (integer div).
//  FSM (uart_pkg::rx_state_t): IDLE, START, DATA, PARITY, STOP.
//   IDLE:   a high->low transition on the synchronised line -> START, cnt=0.
//   START:  at MID, line low -> DATA with cnt reset to MID alignment; line high -> IDLE (glitch, nothing pushed).
//   DATA:   one sample per bit at MID; shift in LSB first; after DATA_BITS samples -> PARITY,
//           or -> STOP when PARITY_MODE=0.
//   PARITY: sample; err = (^data ^ bit) != (PARITY_MODE==1) -> STOP.
//   STOP:   sample STOP_BITS bits; any low sample sets frame_err.
//           At the last stop sample: push {frame_err,parity_err,data}, then -> IDLE the
//           same cycle, so a start edge in the next bit period is caught.
//  Push: write on the clock edge closing the last-stop sample cycle; rx_valid high next cycle.
//   FIFO full at push: frame dropped and overrun <=1; FIFO contents untouched.
//   Simultaneous push and pop while full: pop frees a slot, so the push succeeds and overrun
//   is not set.
//  Pop: rx_valid&rx_ready advances head; rx_valid, rx_data and err bits are registered
//   show-ahead outputs. rx_ready while empty is ignored.
//  Pointers: log2(FIFO_DEPTH)+1 bits; wrap is natural; full/empty come from the MSB compare.
//  Errored frames are still delivered; the consumer decides. Counter width is $clog2(CLKS_PER_BAUD).
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each bit (start, data, parity, stop) is sampled at MID-1, MID
//   and MID+1; the bit value is the 2-of-3 majority; the decision is taken at MID+1; all
//   transitions shift 1 cycle later.
//  Not defined: single sample at MID; no extra latency.
// STRUCTURE
//  uart_pkg: rx_state_t enum, PAR_NONE/PAR_ODD/PAR_EVEN localparams.
//  Sub-module uart_rx_fifo (param WIDTH, DEPTH): sync FIFO, push/pop/full/empty, async
//   active-high reset. The top level holds the synchroniser, baud counter, FSM and overrun flag.
// TESTING (CLKS_PER_BAUD=16, DATA_BITS=8, PARITY_MODE=2, STOP_BITS=1, FIFO_DEPTH=4)
//  1 Reset: rst high for 3 cycles with rx_serial=1 -> all outputs 0, busy=0.
//  2 Frame 0xA5 with even parity bit 0 and stop 1, rx_ready=0 -> rx_valid=1, rx_data=8'hA5,
//    both err=0; then rx_ready=1 for 1 cycle -> rx_valid=0.
//  3 Frame 0x3C with parity bit 1 -> rx_data=8'h3C, rx_parity_err=1.
//    Frame 0x00 with stop=0 -> rx_frame_err=1.
//  4 Start pulse low for 5 cycles only -> returns to IDLE, rx_valid stays 0, busy pulses.
//  5 Send 5 frames 0x01..0x05 with rx_ready=0 -> 4 entries 0x01..0x04, overrun=1;
//    ovr_clr -> overrun=0; drain in order.
//  6 Assert rst during bit 3 of a frame, then send 0x5A -> only 0x5A is received.
//    Repeat with UART_RX_MAJORITY_EN and a 1-cycle glitch at MID -> data is unaffected.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver family.
// Parity encodings and receiver FSM state enumeration.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received frames with their error tags.
// Show-ahead head; a pop in the same cycle frees a slot for a push when full.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_pop;
  logic             w_wr;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_pop);
  assign o_dout  = r_mem[r_rd[AW-1:0]];

  // Storage array and pointers; pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr[AW-1:0]] <= i_din;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Parametrised oversampling UART receiver feeding a frame FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BAUD = 1250,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 2,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  input  logic                 ovr_clr,
  output logic                 busy
);

  localparam int CW  = $clog2(CLKS_PER_BAUD);
  localparam int FW  = DATA_BITS + 2;
  localparam int MID = CLKS_PER_BAUD / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = MID + 1;
`else
  localparam int DEC = MID;
`endif
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BAUD - 1);
  localparam logic [CW-1:0] C_DEC  = CW'(DEC);
  localparam logic [3:0]    B_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    S_LAST = 4'(STOP_BITS - 1);

  rx_state_t            r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync_d;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 w_tick;
  logic                 w_bit;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [FW-1:0]        w_din;
  logic [FW-1:0]        w_dout;

  // Two-flop synchroniser plus a delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= rx_serial;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic r_sa;
  logic r_sb;

  // Capture the two early votes at MID-1 and MID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa <= 1'b1;
      r_sb <= 1'b1;
    end else begin
      if (r_cnt == CW'(MID - 1)) r_sa <= r_sync2;
      if (r_cnt == CW'(MID))     r_sb <= r_sync2;
    end
  end

  assign w_bit = (r_sa & r_sb) | (r_sa & r_sync2) |
                 (r_sb & r_sync2);
`else
  assign w_bit = r_sync2;
`endif

  assign w_tick = (r_cnt == C_DEC);
  assign busy   = (r_state != ST_IDLE);
  assign w_push = (r_state == ST_STOP) && w_tick &&
                  (r_bitcnt == S_LAST);
  assign w_din  = {r_ferr | ~w_bit, r_perr, r_shift};
  assign w_pop  = rx_valid & rx_ready;

  // Baud counter and frame FSM; counter keeps running so
  // each bit decision lands one baud period after the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          r_cnt    <= '0;
          r_bitcnt <= '0;
          r_perr   <= 1'b0;
          r_ferr   <= 1'b0;
          if (r_sync_d & ~r_sync2) r_state <= ST_START;
        end
        ST_START: begin
          if (w_tick) r_state <= w_bit ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            if (r_bitcnt == B_LAST) begin
              r_bitcnt <= '0;
              r_state  <= (PARITY_MODE == PAR_NONE) ?
                          ST_STOP : ST_PARITY;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_perr  <= ((^r_shift) ^ w_bit) !=
                       (PARITY_MODE == PAR_ODD);
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (!w_bit) r_ferr <= 1'b1;
            if (r_bitcnt == S_LAST) r_state <= ST_IDLE;
            else r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overrun: a push into a full FIFO without a pop drops
  // the frame; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else if (w_push & w_full & ~w_pop) overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rx_valid      = ~w_empty;
  assign rx_data       = w_dout[DATA_BITS-1:0];
  assign rx_parity_err = w_dout[DATA_BITS];
  assign rx_frame_err  = w_dout[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed and randomized bench for uart_rx_ovs.
// Expected frames come from a queue model of the wire protocol.
module tb_uart_rx_ovs;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       overrun;
  logic       ovr_clr = 1'b0;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] q_exp [$];
  logic       m_ovr;

  uart_rx_ovs #(
    .CLKS_PER_BAUD (CPB),
    .DATA_BITS     (8),
    .PARITY_MODE   (2),
    .STOP_BITS     (1),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_serial     (rx_serial),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .overrun       (overrun),
    .ovr_clr       (ovr_clr),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Wire frame; model entry pushed only if the frame completes.
  task automatic send_frame(input logic [7:0] d, input logic pb,
                            input logic sb);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(pb);
    drive_bit(sb);
    drive_bit(1'b1);
    drive_bit(1'b1);
    if (q_exp.size() < 4) q_exp.push_back({~sb, pb != (^d), d});
    else m_ovr = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    logic [9:0] e;
    n = q_exp.size();
    for (int i = 0; i < n; i++) begin
      e = q_exp.pop_front();
      chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
      chk({tag, "_head"},
          32'({rx_frame_err, rx_parity_err, rx_data}), 32'(e));
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    chk({tag, "_empty"}, 32'(rx_valid), 32'd0);
  endtask

  task automatic clr_ovr();
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    m_ovr = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       pb;
    logic       sb;
    int         k;
    m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_errs", 32'({rx_parity_err, rx_frame_err}), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send_frame(8'hA5, 1'b0, 1'b1);
    chk("a5_valid", 32'(rx_valid), 32'd1);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_errs", 32'({rx_parity_err, rx_frame_err}), 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    void'(q_exp.pop_front());
    chk("a5_popped", 32'(rx_valid), 32'd0);

    send_frame(8'h3C, 1'b1, 1'b1);
    chk("3c_data", 32'(rx_data), 32'h3C);
    chk("3c_perr", 32'(rx_parity_err), 32'd1);
    send_frame(8'h00, 1'b0, 1'b0);
    drain("perr_ferr");

    rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    rx_serial = 1'b1;
    chk("glitch_busy", 32'(busy), 32'd1);
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_idle", 32'(busy), 32'd0);
    chk("glitch_valid", 32'(rx_valid), 32'd0);

    for (int i = 1; i <= 5; i++)
      send_frame(8'(i), ^(8'(i)), 1'b1);
    chk("ovf_ovr", 32'(overrun), 32'(m_ovr));
    clr_ovr();
    chk("ovf_clr", 32'(overrun), 32'd0);
    drain("ovf");

    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx_serial = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    rx_serial = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (CPB) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1);
    drain("midrst");

`ifdef UART_RX_MAJORITY_EN
    d = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      repeat (CPB / 2) @(negedge clk);
      rx_serial = ~d[i];
      @(negedge clk);
      rx_serial = d[i];
      repeat (CPB / 2 - 1) @(negedge clk);
    end
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    q_exp.push_back({1'b0, 1'b0, d});
    drain("maj");
`endif

    for (int r = 0; r < 5; r++) begin
      k = $urandom_range(1, 6);
      for (int j = 0; j < k; j++) begin
        d  = 8'($urandom);
        pb = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
        sb = ($urandom_range(0, 3) != 0);
        send_frame(d, pb, sb);
      end
      chk("rnd_ovr", 32'(overrun), 32'(m_ovr));
      clr_ovr();
      drain("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
